// File: rtl/vrf_elem_sequencer_if.sv
// rtl/vrf_elem_sequencer_if.sv - command, host and VRF port bundle of the element sequencer
// cmd_vx/cmd_scalar exist only when VSEQ_VX_EN is defined.
interface vrf_elem_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_vs1;
  logic [ADDR_WIDTH-1:0] cmd_vs2;
  logic [ADDR_WIDTH-1:0] cmd_vd;
  logic [ADDR_WIDTH:0]   cmd_vl;
`ifdef VSEQ_VX_EN
  logic                  cmd_vx;
  logic [DATA_WIDTH-1:0] cmd_scalar;
`endif
  logic                  done;
  logic                  busy;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_vreg;
  logic [ADDR_WIDTH-1:0] host_elem;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic [DATA_WIDTH-1:0] host_rdata;

  logic [ADDR_WIDTH-1:0] vrf_rvreg1;
  logic [ADDR_WIDTH-1:0] vrf_relem1;
  logic [ADDR_WIDTH-1:0] vrf_rvreg2;
  logic [ADDR_WIDTH-1:0] vrf_relem2;
  logic [DATA_WIDTH-1:0] vrf_rdata1;
  logic [DATA_WIDTH-1:0] vrf_rdata2;
  logic [ADDR_WIDTH-1:0] vrf_wvreg;
  logic [ADDR_WIDTH-1:0] vrf_welem;
  logic [DATA_WIDTH-1:0] vrf_wdata;
  logic                  vrf_wen;

  // master: decoder/host/VRF environment; slave: the sequencer itself
  modport master (
    output cmd_valid, cmd_op, cmd_vs1, cmd_vs2, cmd_vd, cmd_vl,
`ifdef VSEQ_VX_EN
    output cmd_vx, cmd_scalar,
`endif
    input  cmd_ready, done, busy,
    output host_req, host_we, host_vreg, host_elem, host_wdata,
    input  host_ack, host_rdata,
    input  vrf_rvreg1, vrf_relem1, vrf_rvreg2, vrf_relem2,
    output vrf_rdata1, vrf_rdata2,
    input  vrf_wvreg, vrf_welem, vrf_wdata, vrf_wen
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_vs1, cmd_vs2, cmd_vd, cmd_vl,
`ifdef VSEQ_VX_EN
    input  cmd_vx, cmd_scalar,
`endif
    output cmd_ready, done, busy,
    input  host_req, host_we, host_vreg, host_elem, host_wdata,
    output host_ack, host_rdata,
    output vrf_rvreg1, vrf_relem1, vrf_rvreg2, vrf_relem2,
    input  vrf_rdata1, vrf_rdata2,
    output vrf_wvreg, vrf_welem, vrf_wdata, vrf_wen
  );
endinterface

// File: rtl/vrf_elem_sequencer.sv
// rtl/vrf_elem_sequencer.sv - element-wise vector ALU sequencer with idle-time host port
// Optional VSEQ_VX_EN adds a latched scalar operand (cmd_vx/cmd_scalar) replacing vs2.
module vrf_elem_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ELE    = 32
) (
  input logic                 clk,
  input logic                 reset,
  vrf_elem_sequencer_if.slave bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] MAX_VL = (ADDR_WIDTH+1)'(NUM_ELE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] vs1_q;
  logic [ADDR_WIDTH-1:0] vs2_q;
  logic [ADDR_WIDTH-1:0] vd_q;
  logic [ADDR_WIDTH:0]   vl_q;
  logic [ADDR_WIDTH-1:0] cnt_q;

  logic                  pipe_valid_q;
  logic [ADDR_WIDTH-1:0] pipe_elem_q;
  logic [DATA_WIDTH-1:0] pipe_data_q;

  logic                  done_q;
  logic                  host_ack_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;

  logic                  use_scalar;
  logic                  cmd_fire;
  logic                  host_go;
  logic                  last_elem;
  logic [ADDR_WIDTH:0]   vl_clamped;
  logic [DATA_WIDTH-1:0] opb;
  logic [DATA_WIDTH-1:0] alu_res;

`ifdef VSEQ_VX_EN
  logic                  vx_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  assign use_scalar = vx_q;
  assign opb        = vx_q ? scalar_q : bus.vrf_rdata2;
`else
  assign use_scalar = 1'b0;
  assign opb        = bus.vrf_rdata2;
`endif

  assign bus.cmd_ready  = (state_q == IDLE) && !host_ack_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.host_rdata = host_rdata_q;

  // A command accepted in the same cycle always wins; the host simply keeps requesting.
  assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
  assign host_go    = (state_q == IDLE) && bus.host_req && !host_ack_q && !cmd_fire;
  assign vl_clamped = (bus.cmd_vl > MAX_VL) ? MAX_VL : bus.cmd_vl;
  assign last_elem  = ({1'b0, cnt_q} == (vl_q - (ADDR_WIDTH+1)'(1)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire && (bus.cmd_vl != '0)) state_d = RUN;
      RUN:     if (last_elem) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      3'd0: alu_res = bus.vrf_rdata1 + opb;
      3'd1: alu_res = bus.vrf_rdata1 - opb;
      3'd2: alu_res = bus.vrf_rdata1 & opb;
      3'd3: alu_res = bus.vrf_rdata1 | opb;
      3'd4: alu_res = bus.vrf_rdata1 ^ opb;
      3'd5: alu_res = bus.vrf_rdata1 << opb[SHW-1:0];
      3'd6: alu_res = bus.vrf_rdata1 >> opb[SHW-1:0];
      3'd7: alu_res = bus.vrf_rdata1 * opb;
      default: alu_res = '0;
    endcase
  end

  // Read ports: element walk while running, host read borrows port 1 while idle.
  always_comb begin
    bus.vrf_rvreg1 = '0;
    bus.vrf_relem1 = '0;
    bus.vrf_rvreg2 = '0;
    bus.vrf_relem2 = '0;
    if (state_q == RUN) begin
      bus.vrf_rvreg1 = vs1_q;
      bus.vrf_relem1 = cnt_q;
      if (!use_scalar) begin
        bus.vrf_rvreg2 = vs2_q;
        bus.vrf_relem2 = cnt_q;
      end
    end else if (host_go && !bus.host_we) begin
      bus.vrf_rvreg1 = bus.host_vreg;
      bus.vrf_relem1 = bus.host_elem;
    end
  end

  // Pipe writes only happen in RUN/DRAIN, host writes only in IDLE, so they never collide.
  always_comb begin
    bus.vrf_wen   = 1'b0;
    bus.vrf_wvreg = '0;
    bus.vrf_welem = '0;
    bus.vrf_wdata = '0;
    if (pipe_valid_q) begin
      bus.vrf_wen   = 1'b1;
      bus.vrf_wvreg = vd_q;
      bus.vrf_welem = pipe_elem_q;
      bus.vrf_wdata = pipe_data_q;
    end else if (host_go && bus.host_we) begin
      bus.vrf_wen   = 1'b1;
      bus.vrf_wvreg = bus.host_vreg;
      bus.vrf_welem = bus.host_elem;
      bus.vrf_wdata = bus.host_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      vl_q         <= '0;
      cnt_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_elem_q  <= '0;
      pipe_data_q  <= '0;
      done_q       <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
`ifdef VSEQ_VX_EN
      vx_q         <= 1'b0;
      scalar_q     <= '0;
`endif
    end else begin
      done_q       <= 1'b0;
      host_ack_q   <= host_go;
      pipe_valid_q <= (state_q == RUN);
      if (host_go && !bus.host_we) begin
        host_rdata_q <= bus.vrf_rdata1;
      end
      if (state_q == RUN) begin
        pipe_elem_q <= cnt_q;
        pipe_data_q <= alu_res;
        cnt_q       <= cnt_q + ADDR_WIDTH'(1);
      end
      if (state_q == DRAIN) begin
        done_q <= 1'b1;
      end
      if (cmd_fire) begin
        op_q  <= bus.cmd_op;
        vs1_q <= bus.cmd_vs1;
        vs2_q <= bus.cmd_vs2;
        vd_q  <= bus.cmd_vd;
        vl_q  <= vl_clamped;
        cnt_q <= '0;
`ifdef VSEQ_VX_EN
        vx_q     <= bus.cmd_vx;
        scalar_q <= bus.cmd_scalar;
`endif
        if (bus.cmd_vl == '0) begin
          done_q <= 1'b1;
        end
      end
    end
  end
endmodule
